shift_rows_pipe: RTL
====================

Name: shift_rows_pipe

Overview:
- Parametrised, registered successor to the combinational ShiftRows stage. Covers forward ShiftRows and InvShiftRows, selected per transaction.
- Supports Rijndael block widths Nb = 4, 6 or 8 columns, i.e. 128, 192 or 256 bits.
- Sits between SubBytes/InvSubBytes and MixColumns/AddRoundKey in the round datapath.
- Valid/ready handshaking on both sides, with a 2-entry elastic buffer so that in_ready is registered and throughput is one block per cycle.

Parameters:
- NB, 4: state columns. Legal values are 4, 6 and 8. Any other value must cause an elaboration error.
- W, 32*NB: state width in bits. Derived; must not be overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input block valid.
- in_ready  out  1  buffer can accept a block.
- in_inv  in  1  mode: 0 = ShiftRows (encrypt), 1 = InvShiftRows (decrypt). Sampled with in_data.
- in_data  in  W  input state.
- out_valid  out  1  output block valid.
- out_ready  in  1  downstream accepts the block.
- out_data  out  W  shifted state.
- out_inv  out  1  mode that accompanied this block.

Behaviour:
- Byte mapping: state byte k = r + 4c (r = row 0..3, c = column 0..NB-1) sits at in_data[W-1-8k -: 8]. Byte 0 is the MSB byte. The same mapping applies to out_data.
- Row offsets C_r:
  - NB = 4 or 6: C0=0, C1=1, C2=2, C3=3.
  - NB = 8: C0=0, C1=1, C2=3, C3=4.
- Forward transform: out[r][c] = in[r][(c + C_r) mod NB].
- Inverse transform: out[r][c] = in[r][(c - C_r + NB) mod NB].
- The transform is applied combinationally on the input side. The buffer stores already-transformed data plus out_inv.
- Buffer: 2 entries, FIFO order, with a 2-bit occupancy count.
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (count != 2) and is driven directly from a register.
  - out_valid = (count != 0).
  - out_data and out_inv always present the head entry.
- Latency: a block accepted at edge N is visible on out_data/out_valid after edge N, i.e. 1 cycle. This holds when the buffer is empty or holds one entry that pops on the same edge.
- Simultaneous push and pop: count is unchanged, order is preserved, and no bubble is inserted.
  - When count = 1, the head is replaced by the new block.
  - When count = 2, push cannot occur because in_ready = 0.
- Full: in_ready deasserts on the cycle after the second entry is written. Upstream must then hold in_valid, in_data and in_inv.
- Empty: out_valid = 0 and out_data holds its last value. The bench must not check out_data while out_valid = 0.
- Stall: while out_valid = 1 and out_ready = 0, out_data and out_inv are stable.
- Mode can change on every block with no turnaround cycle.
- Reset (rst_n = 0 at a rising edge):
  - count = 0, out_valid = 0, in_ready = 1.
  - out_data = 0 and out_inv = 0; storage entries are cleared.
  - Reset asserted mid-transfer drops all buffered blocks. Any push or pop offered in that cycle is ignored.
- No X may propagate from the buffer to the outputs after reset.

Test Plan:
- Forward, NB=4 (FIPS-197 App. B, round 1): in_data=128'hd42711aee0bf98f1b8b45de51e415230, in_inv=0 -> out_data=128'hd4bf5d30e0b452aeb84111f11e2798e5, one cycle later, with out_inv=0.
- Inverse, NB=4: send that output with in_inv=1 -> original 128'hd42711ae...1e415230 is returned. Alternating inv/fwd on back-to-back cycles must sustain 1 block/cycle with no bubbles.
- NB=8, forward: byte k = k (00..1f) -> first two output words are 32'h00050e13 and 32'h04091217. Inverse of that output restores 00..1f. Repeat the round trip with NB=6.
- Backpressure: stream 5 blocks with out_ready=0 -> in_ready falls after 2 accepts and out_data stays on block 0. Then set out_ready=1 -> blocks 0..4 emerge in order, each exactly once.
- Reset mid-operation: with 2 entries held, pulse rst_n=0 for one cycle -> next cycle out_valid=0, in_ready=1, out_data=0, and none of the held blocks ever appears.
- Randomised throughput: random in_valid/out_ready, scoreboard against a reference model -> no loss, no duplication, order preserved, and in_ready never 1 while count=2.

Source files
------------

// File: rtl/shift_rows_pipe.sv
// -----------------------------------------------------------------------------
// shift_rows_pipe
//   Registered ShiftRows / InvShiftRows stage for Rijndael states of NB = 4, 6
//   or 8 columns. The row rotation is applied combinationally to the incoming
//   block. The already-transformed block and its mode bit are then written
//   into a 2-entry elastic FIFO. This keeps in_ready registered and sustains
//   one block per cycle.
//
//   Handshake: a transfer happens on a rising edge where valid & ready are both
//   1. The producer must hold valid, data and mode stable until that edge.
//   out_data/out_inv always show the FIFO head and stay stable while stalled.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   input block valid
//   in_ready   buffer can accept a block (registered)
//   in_inv     0 = ShiftRows, 1 = InvShiftRows, sampled with in_data
//   in_data    input state, byte k = r + 4c at in_data[W-1-8k -: 8]
//   out_valid  output block valid (buffer not empty)
//   out_ready  downstream accepts the head block
//   out_data   shifted state (head entry)
//   out_inv    mode that accompanied the head entry
// -----------------------------------------------------------------------------
module shift_rows_pipe #(
   parameter int NB = 4,
   parameter int W  = 32 * NB
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_inv,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_inv
);

   // Reject block sizes Rijndael does not define, and a hand-overridden width.
   if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("shift_rows_pipe: NB must be 4, 6 or 8");
   end
   if (W != 32 * NB) begin : g_bad_w
      $error("shift_rows_pipe: W must equal 32*NB");
   end

   // ---------------------------------------------------------------------------
   // Row rotation. Source columns are elaboration constants, so each output byte
   // is just a 2:1 mux between its forward and inverse source byte.
   // ---------------------------------------------------------------------------
   logic [W-1:0] xform;

   for (genvar r = 0; r < 4; r++) begin : g_row
      // The wide block moves rows 2 and 3 one column further.
      localparam int OFF = (NB == 8 && r >= 2) ? r + 1 : r;
      for (genvar c = 0; c < NB; c++) begin : g_col
         localparam int FSRC = (c + OFF) % NB;
         localparam int ISRC = (c - OFF + NB) % NB;
         assign xform[W-1-8*(r+4*c) -: 8] = in_inv ? in_data[W-1-8*(r+4*ISRC) -: 8]
                                                   : in_data[W-1-8*(r+4*FSRC) -: 8];
      end
   end

   // ---------------------------------------------------------------------------
   // Two-entry FIFO: head (drives the outputs directly) and tail.
   // ---------------------------------------------------------------------------
   logic [1:0]   count;
   logic [W-1:0] head_data;
   logic [W-1:0] tail_data;
   logic         head_inv;
   logic         tail_inv;
   logic         push;
   logic         pop;

   assign out_valid = (count != 2'd0);
   assign out_data  = head_data;
   assign out_inv   = head_inv;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count     <= 2'd0;
         in_ready  <= 1'b1;
         head_data <= '0;
         tail_data <= '0;
         head_inv  <= 1'b0;
         tail_inv  <= 1'b0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) begin
                  head_data <= xform;
                  head_inv  <= in_inv;
               end else begin
                  tail_data <= xform;
                  tail_inv  <= in_inv;
               end
               count    <= count + 2'd1;
               // Going from 1 to 2 entries fills the buffer.
               in_ready <= (count != 2'd1);
            end
            2'b01: begin
               // When the last entry leaves, the head keeps its old value.
               if (count == 2'd2) begin
                  head_data <= tail_data;
                  head_inv  <= tail_inv;
               end
               count    <= count - 2'd1;
               in_ready <= 1'b1;
            end
            2'b11: begin
               // Only reachable with one entry: the new block replaces the head.
               head_data <= xform;
               head_inv  <= in_inv;
            end
            default: ;
         endcase
      end
   end

endmodule
